// File: rtl/uart_tx_buffer_injector.sv
// UART TX injector: a circular byte buffer that feeds a tx_uart serializer one frame at a time, with a start/done handshake and a programmable gap between frames.
// o_start_tx goes high 2 cycles after i_start. The block waits in FETCH while the buffer is empty. The WAIT_DONE watchdog is built only when UART_INJ_TIMEOUT_EN is defined.
module uart_tx_buffer_injector #(
    parameter int G_DATA_WIDTH        = 8,
    parameter int G_BUFFER_ADDR_WIDTH = 8,
    parameter int G_GAP_WIDTH         = 16,
    parameter int G_TIMEOUT_CYCLES    = 1000000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_wr_en,
    input  logic [G_DATA_WIDTH-1:0]        i_wr_data,
    input  logic                           i_clr,
    input  logic                           i_start,
    input  logic [G_BUFFER_ADDR_WIDTH:0]   i_nb_bytes,
    input  logic [G_GAP_WIDTH-1:0]         i_gap,
    output logic                           o_start_tx,
    output logic [G_DATA_WIDTH-1:0]        o_tx_data,
    input  logic                           i_tx_done,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [G_BUFFER_ADDR_WIDTH:0]   o_sent_cnt,
    output logic [G_BUFFER_ADDR_WIDTH:0]   o_level,
    output logic                           o_full,
    output logic                           o_empty,
    output logic                           o_wr_err,
    output logic                           o_timeout
);

    localparam int A     = G_BUFFER_ADDR_WIDTH;
    localparam int LW    = A + 1;
    localparam int GW    = G_GAP_WIDTH;
    localparam int DEPTH = 2 ** A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_START,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [G_DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [A-1:0]            r_wr_ptr;
    logic [A-1:0]            r_rd_ptr;
    logic [LW-1:0]           r_level;
    logic                    r_tx_done_q;
    logic [LW-1:0]           r_remaining;
    logic [GW-1:0]           r_gap;
    logic [GW-1:0]           r_gap_cnt;
    logic [LW-1:0]           r_sent_cnt;
    logic [G_DATA_WIDTH-1:0] r_tx_data;
    logic                    r_start_tx;
    logic                    r_done;
    logic                    r_wr_err;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_acc;
    logic                    w_tx_rise;
    logic [LW-1:0]           w_start_rem;
    logic                    w_pop;
    logic                    w_run_load;
    logic                    w_frame_done;
    logic                    w_gap_load;
    logic                    w_done_set;

    assign w_full      = (r_level == LW'(DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_wr_acc    = i_wr_en && !w_full && !i_clr;
    assign w_tx_rise   = i_tx_done && !r_tx_done_q;
    assign w_start_rem = (i_nb_bytes == '0) ? r_level : i_nb_bytes;

`ifdef UART_INJ_TIMEOUT_EN
    localparam int TW = $clog2(G_TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;
    logic          w_to_hit;
    logic          w_to_fire;

    assign w_to_hit = (r_to_cnt == TW'(G_TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_run_load   = 1'b0;
        w_frame_done = 1'b0;
        w_gap_load   = 1'b0;
        w_done_set   = 1'b0;
`ifdef UART_INJ_TIMEOUT_EN
        w_to_fire    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_run_load = 1'b1;
                    if (w_start_rem == '0) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_next = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_START;
                end
            end
            S_START: begin
                w_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (w_tx_rise) begin
                    w_frame_done = 1'b1;
                    if (r_remaining == LW'(1)) begin
                        w_done_set = 1'b1;
                        w_next     = S_IDLE;
                    end else if (r_gap == '0) begin
                        w_next = S_FETCH;
                    end else begin
                        w_gap_load = 1'b1;
                        w_next     = S_GAP;
                    end
                end
`ifdef UART_INJ_TIMEOUT_EN
                else if (w_to_hit) begin
                    w_to_fire = 1'b1;
                    w_next    = S_IDLE;
                end
`endif
            end
            S_GAP: begin
                if (r_gap_cnt <= GW'(1)) begin
                    w_next = S_FETCH;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Clear overrides everything, including a start or a write in the same cycle.
        if (i_clr) begin
            w_next       = S_IDLE;
            w_pop        = 1'b0;
            w_run_load   = 1'b0;
            w_frame_done = 1'b0;
            w_gap_load   = 1'b0;
            w_done_set   = 1'b0;
`ifdef UART_INJ_TIMEOUT_EN
            w_to_fire    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_wr_err <= 1'b0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_wr_err <= 1'b0;
        end else begin
            // A write is judged full on the pre-edge level, so a same-cycle pop does not save it.
            r_wr_err <= i_wr_en && w_full;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_done_q <= 1'b0;
            r_tx_data   <= '0;
            r_start_tx  <= 1'b0;
            r_done      <= 1'b0;
            r_sent_cnt  <= '0;
            r_remaining <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_tx_done_q <= i_tx_done;
            r_start_tx  <= (r_state == S_START) && !i_clr;
            r_done      <= w_done_set;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
            if (i_clr) begin
                r_sent_cnt  <= '0;
                r_remaining <= '0;
            end else if (w_run_load) begin
                r_sent_cnt  <= '0;
                r_remaining <= w_start_rem;
                r_gap       <= i_gap;
            end else if (w_frame_done) begin
                r_sent_cnt  <= r_sent_cnt + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end
            if (w_gap_load) begin
                r_gap_cnt <= r_gap;
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

`ifdef UART_INJ_TIMEOUT_EN
    // The counter stays at zero outside WAIT_DONE, so each entry starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_WAIT_DONE && !i_clr) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (i_clr) begin
                r_timeout <= 1'b0;
            end else if (w_to_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_start_tx = r_start_tx;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_sent_cnt = r_sent_cnt;
    assign o_level    = r_level;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_wr_err   = r_wr_err;

endmodule

// File: tb/tb_uart_tx_buffer_injector.sv
// Bench for uart_tx_buffer_injector: a queue model of the buffer plus a randomized serializer responder.
// Frame order, counts, handshake timing, clear and reset behaviour are checked against the model.
module tb_uart_tx_buffer_injector;

    localparam int DW      = 8;
    localparam int A       = 8;
    localparam int GW      = 16;
    localparam int DEPTH   = 256;
`ifdef UART_INJ_TIMEOUT_EN
    localparam int TO      = 100;
`else
    localparam int TO      = 1000000;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_wr_en = 1'b0;
    logic [DW-1:0]  i_wr_data = '0;
    logic           i_clr = 1'b0;
    logic           i_start = 1'b0;
    logic [A:0]     i_nb_bytes = '0;
    logic [GW-1:0]  i_gap = '0;
    logic           o_start_tx;
    logic [DW-1:0]  o_tx_data;
    logic           o_busy, o_done, o_full, o_empty, o_wr_err, o_timeout;
    logic [A:0]     o_sent_cnt, o_level;
    logic           resp_done = 1'b0;
    logic           spur_done = 1'b0;
    logic           tx_line;

    assign tx_line = resp_done | spur_done;

    always #5 clk = ~clk;

    uart_tx_buffer_injector #(
        .G_DATA_WIDTH(DW), .G_BUFFER_ADDR_WIDTH(A), .G_GAP_WIDTH(GW), .G_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_wr_en(i_wr_en), .i_wr_data(i_wr_data), .i_clr(i_clr),
        .i_start(i_start), .i_nb_bytes(i_nb_bytes), .i_gap(i_gap), .o_start_tx(o_start_tx),
        .o_tx_data(o_tx_data), .i_tx_done(tx_line), .o_busy(o_busy), .o_done(o_done),
        .o_sent_cnt(o_sent_cnt), .o_level(o_level), .o_full(o_full), .o_empty(o_empty),
        .o_wr_err(o_wr_err), .o_timeout(o_timeout)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_edge = 0;
    int lat_min = 1;
    int lat_max = 4;
    bit resp_en = 1'b1;
    logic [DW-1:0] mdl_q[$];
    logic [DW-1:0] obs_q[$];
    int st_q[$];
    int done_q[$];
    int rise_q[$];
    int to_q[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Passive monitor: records the cycle of every handshake event.
    logic to_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (o_start_tx) begin
            obs_q.push_back(o_tx_data);
            st_q.push_back(cyc);
        end
        if (o_done) done_q.push_back(cyc);
        if (o_timeout && !to_prev) to_q.push_back(cyc);
        to_prev = o_timeout;
    end

    // Serializer stand-in: raises done a random number of cycles after each start pulse.
    always @(posedge clk) begin
        #1;
        if (o_start_tx && resp_en) begin
            repeat ($urandom_range(lat_max, lat_min)) @(posedge clk);
            #1;
            resp_done = 1'b1;
            rise_q.push_back(cyc + 1);
            @(posedge clk);
            #1;
            resp_done = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        bit exp_err;
        exp_err = (mdl_q.size() == DEPTH);
        i_wr_en = 1'b1;
        i_wr_data = d;
        step();
        i_wr_en = 1'b0;
        check_val("wr_err", o_wr_err, exp_err);
        if (!exp_err) mdl_q.push_back(d);
        check_val("level_after_wr", o_level, mdl_q.size());
    endtask

    task automatic check_status();
        check_val("level", o_level, mdl_q.size());
        check_val("empty", o_empty, mdl_q.size() == 0);
        check_val("full", o_full, mdl_q.size() == DEPTH);
    endtask

    task automatic clear_all();
        i_clr = 1'b1;
        step();
        i_clr = 1'b0;
        mdl_q.delete();
    endtask

    // One complete run: start, wait for o_done, then compare against the model.
    task automatic run(input int nb, input int gap, input bit timing);
        int exp_n, bs, bd, br, budget;
        exp_n = (nb == 0) ? mdl_q.size() : nb;
        bs = obs_q.size();
        bd = done_q.size();
        br = rise_q.size();
        i_start = 1'b1;
        i_nb_bytes = (A + 1)'(nb);
        i_gap = GW'(gap);
        step();
        start_edge = cyc;
        i_start = 1'b0;
        budget = exp_n * (gap + lat_max + 8) + 20;
        while (done_q.size() == bd && budget > 0) begin
            step();
            budget--;
        end
        check_val("run_done_count", done_q.size() - bd, 1);
        step();
        check_val("busy_after_run", o_busy, 1'b0);
        check_val("sent_cnt", o_sent_cnt, exp_n);
        check_val("start_count", obs_q.size() - bs, exp_n);
        for (int k = 0; k < exp_n; k++) begin
            logic [DW-1:0] exp_d;
            exp_d = mdl_q.pop_front();
            if (bs + k < obs_q.size()) check_val("tx_data", obs_q[bs + k], exp_d);
            if (timing && bs + k < st_q.size()) begin
                if (k == 0) check_val("start_latency", st_q[bs] - start_edge, 2);
                else if (br + k - 1 < rise_q.size())
                    check_val("gap_latency", st_q[bs + k] - rise_q[br + k - 1], gap + 2);
            end
        end
        if (exp_n > 0 && timing && done_q.size() > bd && rise_q.size() >= br + exp_n)
            check_val("done_edge", done_q[bd], rise_q[br + exp_n - 1]);
        if (exp_n == 0 && done_q.size() > bd)
            check_val("empty_run_done_edge", done_q[bd], start_edge);
        check_status();
    endtask

    initial begin
        int bs, bd, budget, st0;
        repeat (3) step();
        check_val("rst_busy", o_busy, 1'b0);
        check_val("rst_start_tx", o_start_tx, 1'b0);
        check_val("rst_tx_data", o_tx_data, 0);
        check_val("rst_done", o_done, 1'b0);
        check_val("rst_sent", o_sent_cnt, 0);
        check_val("rst_level", o_level, 0);
        check_val("rst_empty", o_empty, 1'b1);
        check_val("rst_full", o_full, 1'b0);
        check_val("rst_wr_err", o_wr_err, 1'b0);
        check_val("rst_timeout", o_timeout, 1'b0);
        rst_n = 1'b1;
        step();

        // Three bytes, whole level, no gap.
        wr(8'h55); wr(8'hA3); wr(8'h0F);
        run(0, 0, 1'b1);

        // Gap of 10 between two frames.
        wr(8'($urandom)); wr(8'($urandom));
        run(0, 10, 1'b1);

        // Fill to full, overflow once, then drain everything (pointers wrap).
        for (int i = 0; i < DEPTH; i++) wr(8'(i));
        check_val("full_flag", o_full, 1'b1);
        wr(8'hEE);
        check_val("full_level", o_level, DEPTH);
        run(0, 0, 1'b1);
        wr(8'hC1); wr(8'hC2); wr(8'hC3);
        run(0, 1, 1'b1);

        // Streaming: start on an empty buffer, feed bytes later.
        bs = obs_q.size();
        bd = done_q.size();
        i_start = 1'b1; i_nb_bytes = 9'd2; i_gap = '0;
        step();
        i_start = 1'b0;
        repeat (50) step();
        check_val("stall_no_start", obs_q.size() - bs, 0);
        check_val("stall_busy", o_busy, 1'b1);
        wr(8'h11);
        budget = 40;
        while (obs_q.size() == bs && budget > 0) begin step(); budget--; end
        if (obs_q.size() > bs) check_val("stream_d0", obs_q[bs], mdl_q.pop_front());
        else check_val("stream_d0_seen", 0, 1);
        wr(8'h22);
        budget = 60;
        while (done_q.size() == bd && budget > 0) begin step(); budget--; end
        if (obs_q.size() > bs + 1) check_val("stream_d1", obs_q[bs + 1], mdl_q.pop_front());
        else check_val("stream_d1_seen", 0, 1);
        check_val("stream_done", done_q.size() - bd, 1);
        step();
        check_val("stream_sent", o_sent_cnt, 2);

        // Clear while in WAIT_DONE with four frames outstanding.
        for (int i = 0; i < 6; i++) wr(8'($urandom));
        bs = obs_q.size();
        bd = done_q.size();
        i_start = 1'b1; i_nb_bytes = '0; i_gap = '0;
        step();
        i_start = 1'b0;
        budget = 100;
        while (obs_q.size() < bs + 3 && budget > 0) begin step(); budget--; end
        check_val("clr_setup_sent", o_sent_cnt, 2);
        clear_all();
        check_val("clr_busy", o_busy, 1'b0);
        check_val("clr_sent", o_sent_cnt, 0);
        check_status();
        repeat (20) step();
        check_val("clr_no_done", done_q.size() - bd, 0);
        run(0, 0, 1'b1);

        // Clear wins over a same-cycle write and start.
        wr(8'h77);
        i_clr = 1'b1; i_wr_en = 1'b1; i_start = 1'b1; i_nb_bytes = '0;
        step();
        i_clr = 1'b0; i_wr_en = 1'b0; i_start = 1'b0;
        mdl_q.delete();
        check_val("clr_prio_busy", o_busy, 1'b0);
        check_status();

        // A done edge while idle must be ignored.
        spur_done = 1'b1; step(); spur_done = 1'b0; step();
        check_val("spur_busy", o_busy, 1'b0);
        check_val("spur_sent", o_sent_cnt, 0);

        // Randomized runs; leftover bytes carry over between runs.
        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(12, 0);
            for (int j = 0; j < nw; j++) wr(8'($urandom));
            lat_max = $urandom_range(6, 1);
            run($urandom_range(mdl_q.size(), 0), $urandom_range(5, 0), 1'b1);
        end

        // Asynchronous reset mid-run abandons the run and empties the buffer.
        for (int i = 0; i < 4; i++) wr(8'($urandom));
        bd = done_q.size();
        i_start = 1'b1; i_nb_bytes = '0; i_gap = 16'd3;
        step();
        i_start = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        mdl_q.delete();
        check_val("arst_busy", o_busy, 1'b0);
        check_val("arst_level", o_level, 0);
        check_val("arst_empty", o_empty, 1'b1);
        step();
        rst_n = 1'b1;
        repeat (20) step();
        check_val("arst_no_done", done_q.size() - bd, 0);

`ifdef UART_INJ_TIMEOUT_EN
        // Watchdog: hold done low after the start pulse.
        resp_en = 1'b0;
        wr(8'h31); wr(8'h32); wr(8'h33);
        bs = st_q.size();
        bd = done_q.size();
        i_start = 1'b1; i_nb_bytes = '0; i_gap = '0;
        step();
        i_start = 1'b0;
        st0 = to_q.size();
        budget = TO + 30;
        while (to_q.size() == st0 && budget > 0) begin step(); budget--; end
        if (to_q.size() > st0 && st_q.size() > bs) check_val("timeout_cycle", to_q[st0] - st_q[bs], TO);
        else check_val("timeout_seen", 0, 1);
        void'(mdl_q.pop_front());
        check_val("timeout_flag", o_timeout, 1'b1);
        check_val("timeout_busy", o_busy, 1'b0);
        check_val("timeout_no_done", done_q.size() - bd, 0);
        check_status();
        repeat (5) step();
        check_val("timeout_sticky", o_timeout, 1'b1);
        clear_all();
        check_val("timeout_cleared", o_timeout, 1'b0);
        resp_en = 1'b1;
`else
        st0 = 0;
        check_val("timeout_tied", o_timeout, 1'b0);
        check_val("timeout_never_rose", to_q.size(), st0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
